div_rs: RTL and testbench
=========================

Name: div_rs

Overview:
- Reservation station directly upstream of the integer divide functional unit.
- Holds dispatched div/remu ops until both operands are ready. Operands arrive as values or as ROB tags woken by CDB broadcasts.
- Issues the oldest ready op to the divider through its valid_in/ready handshake, one op per cycle.
- Sits between dispatch/rename and the divider; snoops the shared CDB.

Parameters:
- DEPTH, 4: number of station entries (2..8).
- TAG_W, 4: ROB tag width; must match CDB_packet_t.dest_ROB_entry.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- flush  in  1  sync mispredict flush; clears all entries
- dispatch_valid  in  1  dispatch request
- dispatch_ready  out  1  station not full
- dispatch_rob  in  TAG_W  destination ROB entry of op
- dispatch_op  in  1  1=div (signed quotient), 0=remu
- src1_val, src2_val  in  32 each  operand values (src1=dividend, src2=divisor)
- src1_rdy, src2_rdy  in  1 each  value valid; else wait on tag
- src1_tag, src2_tag  in  TAG_W each  producer ROB tag when not ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_in  in  CDB_packet_t  CDB broadcast
- fu_ready  in  1  divider idle (divider ready)
- issue_valid  out  1  to divider valid_in
- issue_rob  out  TAG_W  to divider rs_rob_entry
- issue_op  out  1  to divider ALUop
- issue_dividend, issue_divisor  out  32 each  operands
- occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Reset (reset=0, async):
  - all entries invalid; occupancy=0; dispatch_ready=1; issue_valid=0.
  - Reset mid-operation discards every entry, no issue.
- Storage:
  - age-ordered compacting queue; slot 0 is oldest.
  - Per entry: valid, rob, op, and for each operand {val, rdy, tag}.
- Dispatch:
  - Accepted on posedge when dispatch_valid && dispatch_ready.
  - Written to the first free slot after any same-cycle removal.
  - dispatch_ready = (occupancy < DEPTH), registered state only. A full station refuses dispatch even if an issue occurs that cycle.
  - dispatch_valid while !dispatch_ready is ignored; no state change.
- CDB wakeup:
  - Broadcast counts when cdb_valid && !cdb_in.load_step1.
  - Every valid entry operand with rdy=0 and tag==cdb_in.dest_ROB_entry captures cdb_in.result and sets rdy at posedge.
  - Same-cycle dispatch: a dispatched operand with rdy=0 whose tag matches a counting broadcast is captured at allocation. No lost wakeup.
  - Both operands may match the same broadcast; both capture.
- Issue:
  - Eligible entry: valid with both rdy=1 in registered state.
  - issue_valid = fu_ready && any eligible && !flush (combinational). Outputs carry the lowest-index (oldest) eligible entry.
  - When issue_valid, the entry is removed at that posedge; younger entries shift down one slot.
  - Divider drops ready the next cycle, so issue is a single-cycle pulse.
  - When issue_valid=0, issue_rob/op/operands = 0.
- Simultaneous events:
  - Issue, dispatch and wakeup in the same cycle all take effect. Removal and shift happen first, then allocation at the compacted tail, and wakeup applies to the shifted contents.
  - occupancy' = occupancy + accept - issue.
- Flush: highest priority.
  - All entries invalidated at posedge; a same-cycle dispatch is dropped.
  - issue_valid forced 0 that cycle.
- No operand checks: division by zero is the divider's concern.

Optional Feature:
- Macro DIV_RS_WAKEUP_BYPASS_EN.
- Defined: an entry whose only missing operand(s) match the current counting CDB broadcast is issue-eligible that same cycle, with the CDB result forwarded onto issue_dividend/issue_divisor. Oldest-first still applies over the bypassed eligibility.
- Undefined: eligibility uses registered rdy only. Minimum wakeup-to-issue is 1 cycle.

Decomposition:
- structs.svh gains:
  - rs_operand_t {val[31:0], rdy, tag[TAG_W-1:0]}
  - div_rs_entry_t {valid, rob, op, src1, src2}
  - DIV_RS_DEPTH default constant.
- CDB_packet_t is reused unchanged.
- One sub-module, rs_operand_wakeup: combinational tag compare plus capture for one operand, instantiated 2*DEPTH+2 times (entries plus dispatch path).

Test Plan:
- Ready operands:
  - Stimulus: dispatch rob=3, op=1, 100 and 3 both rdy, fu_ready=1.
  - Response: issue_valid next cycle with rob=3, dividend=100, divisor=3; occupancy 1→0.
- Tag wakeup:
  - Stimulus: dispatch rob=5 with src2 tag=7 not ready; 3 cycles later CDB dest=7, result=9, load_step1=0.
  - Response: no issue before the broadcast; issue 1 cycle after with divisor=9. With bypass defined: same cycle.
- load_step1 filter:
  - Stimulus: CDB dest=7 with load_step1=1.
  - Response: entry stays unready; no issue.
- Fill and stall:
  - Stimulus: fu_ready=0; dispatch rob=1,2,3,4.
  - Response: dispatch_ready=0 at occupancy 4; a 5th dispatch is ignored.
  - Then: raise fu_ready for one cycle per issue. Response: issue order is 1,2,3,4.
- Concurrent events:
  - Stimulus: same-cycle dispatch of an op whose tag matches the concurrent CDB broadcast, plus an issue of the oldest entry.
  - Response: new entry lands at the compacted tail already ready; occupancy unchanged.
- Flush and reset:
  - Stimulus: flush with 3 entries and dispatch_valid=1.
  - Response: occupancy=0 next cycle; the dispatch is dropped.
  - Stimulus: asynchronous reset low mid-cycle.
  - Response: issue_valid=0 and dispatch_ready=1 immediately.

Source files
------------

// File: rtl/div_rs_pkg.sv
// Shared types for the divide reservation station: CDB packet, operand and entry records.
// The optional same-cycle wakeup bypass is enabled with DIV_RS_WAKEUP_BYPASS_EN.
package div_rs_pkg;

   localparam int DIV_RS_DEPTH = 4;
   localparam int DIV_RS_TAG_W = 4;

   typedef struct packed {
      logic [DIV_RS_TAG_W-1:0] dest_ROB_entry;
      logic [31:0]             result;
      logic                    load_step1;
   } CDB_packet_t;

   typedef struct packed {
      logic [31:0]             val;
      logic                    rdy;
      logic [DIV_RS_TAG_W-1:0] tag;
   } rs_operand_t;

   typedef struct packed {
      logic                    valid;
      logic [DIV_RS_TAG_W-1:0] rob;
      logic                    op;
      rs_operand_t             src1;
      rs_operand_t             src2;
   } div_rs_entry_t;

endpackage

// File: rtl/rs_operand_wakeup.sv
// One operand's CDB snoop: a waiting operand whose tag matches a counting broadcast
// takes the broadcast result and becomes ready.
module rs_operand_wakeup
   import div_rs_pkg::*;
(
   input  rs_operand_t              opnd_in,
   input  logic                     cdb_hit,
   input  logic [DIV_RS_TAG_W-1:0]  cdb_tag,
   input  logic [31:0]              cdb_result,
   output rs_operand_t              opnd_out
);

   logic match;

   always_comb begin
      match    = cdb_hit && !opnd_in.rdy && (opnd_in.tag == cdb_tag);
      opnd_out = opnd_in;
      if (match) begin
         opnd_out.val = cdb_result;
         opnd_out.rdy = 1'b1;
      end
   end

endmodule

// File: rtl/div_rs.sv
// Age-ordered compacting reservation station in front of the integer divider.
// Define DIV_RS_WAKEUP_BYPASS_EN to let a broadcast make an entry issue-eligible in the same cycle.
module div_rs
   import div_rs_pkg::*;
#(
   parameter int DEPTH = DIV_RS_DEPTH,
   parameter int TAG_W = DIV_RS_TAG_W
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       dispatch_valid,
   output logic                       dispatch_ready,
   input  logic [TAG_W-1:0]           dispatch_rob,
   input  logic                       dispatch_op,
   input  logic [31:0]                src1_val,
   input  logic [31:0]                src2_val,
   input  logic                       src1_rdy,
   input  logic                       src2_rdy,
   input  logic [TAG_W-1:0]           src1_tag,
   input  logic [TAG_W-1:0]           src2_tag,
   input  logic                       cdb_valid,
   input  CDB_packet_t                cdb_in,
   input  logic                       fu_ready,
   output logic                       issue_valid,
   output logic [TAG_W-1:0]           issue_rob,
   output logic                       issue_op,
   output logic [31:0]                issue_dividend,
   output logic [31:0]                issue_divisor,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

   div_rs_entry_t    entries_q [DEPTH];
   div_rs_entry_t    entries_d [DEPTH];
   div_rs_entry_t    woken     [DEPTH+1];
   rs_operand_t      woke1     [DEPTH];
   rs_operand_t      woke2     [DEPTH];
   logic [OCC_W-1:0] occ_q, occ_d;
   rs_operand_t      disp_src1, disp_src2, disp_woke1, disp_woke2;
   logic             cdb_hit;
   logic [DEPTH-1:0] elig;
   logic [IDX_W-1:0] issue_idx;
   div_rs_entry_t    issue_entry;
   logic             accept;
   logic [OCC_W-1:0] tail;

   assign cdb_hit = cdb_valid && !cdb_in.load_step1;

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      rs_operand_wakeup u_src1 (
         .opnd_in    (entries_q[g].src1),
         .cdb_hit    (cdb_hit),
         .cdb_tag    (cdb_in.dest_ROB_entry),
         .cdb_result (cdb_in.result),
         .opnd_out   (woke1[g])
      );
      rs_operand_wakeup u_src2 (
         .opnd_in    (entries_q[g].src2),
         .cdb_hit    (cdb_hit),
         .cdb_tag    (cdb_in.dest_ROB_entry),
         .cdb_result (cdb_in.result),
         .opnd_out   (woke2[g])
      );
   end

   assign disp_src1 = '{val: src1_val, rdy: src1_rdy, tag: src1_tag};
   assign disp_src2 = '{val: src2_val, rdy: src2_rdy, tag: src2_tag};

   rs_operand_wakeup u_disp_src1 (
      .opnd_in    (disp_src1),
      .cdb_hit    (cdb_hit),
      .cdb_tag    (cdb_in.dest_ROB_entry),
      .cdb_result (cdb_in.result),
      .opnd_out   (disp_woke1)
   );
   rs_operand_wakeup u_disp_src2 (
      .opnd_in    (disp_src2),
      .cdb_hit    (cdb_hit),
      .cdb_tag    (cdb_in.dest_ROB_entry),
      .cdb_result (cdb_in.result),
      .opnd_out   (disp_woke2)
   );

   // woken[DEPTH] is an empty sentinel so the shift-down can read one past the end.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         woken[i]      = entries_q[i];
         woken[i].src1 = woke1[i];
         woken[i].src2 = woke2[i];
      end
      woken[DEPTH] = '0;
   end

   always_comb begin
      elig      = '0;
      issue_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef DIV_RS_WAKEUP_BYPASS_EN
         elig[i] = woken[i].valid && woken[i].src1.rdy && woken[i].src2.rdy;
`else
         elig[i] = entries_q[i].valid && entries_q[i].src1.rdy && entries_q[i].src2.rdy;
`endif
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (elig[i]) issue_idx = IDX_W'(i);
      end
`ifdef DIV_RS_WAKEUP_BYPASS_EN
      issue_entry = woken[issue_idx];
`else
      issue_entry = entries_q[issue_idx];
`endif
   end

   assign issue_valid    = fu_ready && (|elig) && !flush;
   assign issue_rob      = issue_valid ? issue_entry.rob      : '0;
   assign issue_op       = issue_valid ? issue_entry.op       : 1'b0;
   assign issue_dividend = issue_valid ? issue_entry.src1.val : '0;
   assign issue_divisor  = issue_valid ? issue_entry.src2.val : '0;

   assign dispatch_ready = (occ_q < DEPTH_C);
   assign occupancy      = occ_q;

   // Remove the issued entry and compact first, then allocate at the new tail.
   always_comb begin
      accept = dispatch_valid && dispatch_ready && !flush;
      tail   = occ_q - OCC_W'(issue_valid);
      occ_d  = occ_q + OCC_W'(accept) - OCC_W'(issue_valid);
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_valid && (IDX_W'(i) >= issue_idx)) entries_d[i] = woken[i+1];
         else                                          entries_d[i] = woken[i];
         if (accept && (OCC_W'(i) == tail)) begin
            entries_d[i].valid = 1'b1;
            entries_d[i].rob   = dispatch_rob;
            entries_d[i].op    = dispatch_op;
            entries_d[i].src1  = disp_woke1;
            entries_d[i].src2  = disp_woke2;
         end
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
         occ_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
         occ_q <= '0;
      end else begin
         entries_q <= entries_d;
         occ_q     <= occ_d;
      end
   end

endmodule

// File: tb/tb_div_rs.sv
// Self-checking bench for div_rs: directed cycle table, async reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_div_rs;
   import div_rs_pkg::*;

`ifdef DIV_RS_WAKEUP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        dispatch_valid;
   logic        dispatch_ready;
   logic [3:0]  dispatch_rob;
   logic        dispatch_op;
   logic [31:0] src1_val, src2_val;
   logic        src1_rdy, src2_rdy;
   logic [3:0]  src1_tag, src2_tag;
   logic        cdb_valid;
   CDB_packet_t cdb_in;
   logic        fu_ready;
   logic        issue_valid;
   logic [3:0]  issue_rob;
   logic        issue_op;
   logic [31:0] issue_dividend, issue_divisor;
   logic [2:0]  occupancy;

   div_rs #(.DEPTH(DEPTH), .TAG_W(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_rob(dispatch_rob), .dispatch_op(dispatch_op),
      .src1_val(src1_val), .src2_val(src2_val),
      .src1_rdy(src1_rdy), .src2_rdy(src2_rdy),
      .src1_tag(src1_tag), .src2_tag(src2_tag),
      .cdb_valid(cdb_valid), .cdb_in(cdb_in), .fu_ready(fu_ready),
      .issue_valid(issue_valid), .issue_rob(issue_rob), .issue_op(issue_op),
      .issue_dividend(issue_dividend), .issue_divisor(issue_divisor),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned fl, dv, rob, op, s1v, s1r, s1t, s2v, s2r, s2t, cv, ls, ct, cr, fu;
      int unsigned e_iv, e_rob, e_op, e_dd, e_dr, e_occ, e_rdy;
   } vec_t;

   typedef struct {
      logic [3:0]  rob;
      logic        op;
      logic [31:0] v1, v2;
      bit          r1, r2;
      logic [3:0]  t1, t2;
   } m_ent_t;

   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;
   vec_t        vq[$];
   m_ent_t      mq[$];

   function automatic vec_t mkv(
      input int unsigned fl, dv, rob, op, s1v, s1r, s1t, s2v, s2r, s2t, cv, ls, ct, cr, fu,
      input int unsigned e_iv, e_rob, e_op, e_dd, e_dr, e_occ, e_rdy);
      vec_t v;
      v.fl = fl; v.dv = dv; v.rob = rob; v.op = op;
      v.s1v = s1v; v.s1r = s1r; v.s1t = s1t; v.s2v = s2v; v.s2r = s2r; v.s2t = s2t;
      v.cv = cv; v.ls = ls; v.ct = ct; v.cr = cr; v.fu = fu;
      v.e_iv = e_iv; v.e_rob = e_rob; v.e_op = e_op; v.e_dd = e_dd; v.e_dr = e_dr;
      v.e_occ = e_occ; v.e_rdy = e_rdy;
      return v;
   endfunction

   function automatic vec_t idle(input int unsigned fu, iv, rob, op, dd, dr, occ, rdy);
      return mkv(0,0,0,0,0,0,0,0,0,0,0,0,0,0,fu, iv,rob,op,dd,dr,occ,rdy);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic apply_in(input vec_t v);
      flush          = v.fl[0];
      dispatch_valid = v.dv[0];
      dispatch_rob   = v.rob[3:0];
      dispatch_op    = v.op[0];
      src1_val       = v.s1v;
      src1_rdy       = v.s1r[0];
      src1_tag       = v.s1t[3:0];
      src2_val       = v.s2v;
      src2_rdy       = v.s2r[0];
      src2_tag       = v.s2t[3:0];
      cdb_valid      = v.cv[0];
      cdb_in.load_step1     = v.ls[0];
      cdb_in.dest_ROB_entry = v.ct[3:0];
      cdb_in.result         = v.cr;
      fu_ready       = v.fu[0];
   endtask

   task automatic chk_outs(input string p, input int unsigned iv, rob, op, dd, dr, occ, rdy);
      chk({p, " issue_valid"},    32'(issue_valid),    iv);
      chk({p, " issue_rob"},      32'(issue_rob),      rob);
      chk({p, " issue_op"},       32'(issue_op),       op);
      chk({p, " issue_dividend"}, issue_dividend,      dd);
      chk({p, " issue_divisor"},  issue_divisor,       dr);
      chk({p, " occupancy"},      32'(occupancy),      occ);
      chk({p, " dispatch_ready"}, 32'(dispatch_ready), rdy);
   endtask

   initial begin
      vec_t v;
      reset = 1'b0;
      apply_in(idle(0,0,0,0,0,0,0,0));
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset", 0, 0, 0, 0, 0, 0, 1);
      reset = 1'b1;
      @(posedge clk); #1;

      // fl,dv,rob,op,s1v,s1r,s1t,s2v,s2r,s2t,cv,ls,ct,cr,fu | iv,rob,op,dd,dr,occ,rdy
      vq.push_back(mkv(0,1,3,1,100,1,0,3,1,0, 0,0,0,0,1, 0,0,0,0,0,0,1));
      vq.push_back(idle(1, 1,3,1,100,3,1,1));
      vq.push_back(idle(1, 0,0,0,0,0,0,1));
      vq.push_back(mkv(0,1,5,0,50,1,0,0,0,7, 0,0,0,0,1, 0,0,0,0,0,0,1));
      vq.push_back(idle(1, 0,0,0,0,0,1,1));
      vq.push_back(idle(1, 0,0,0,0,0,1,1));
      vq.push_back(mkv(0,0,0,0,0,0,0,0,0,0, 1,0,7,9,1, BYP, BYP?5:0, 0, BYP?50:0, BYP?9:0, 1, 1));
      vq.push_back(idle(1, !BYP, !BYP?5:0, 0, !BYP?50:0, !BYP?9:0, BYP?0:1, 1));
      vq.push_back(idle(1, 0,0,0,0,0,0,1));
      vq.push_back(mkv(0,1,6,1,0,0,7,4,1,0, 0,0,0,0,1, 0,0,0,0,0,0,1));
      vq.push_back(mkv(0,0,0,0,0,0,0,0,0,0, 1,1,7,11,1, 0,0,0,0,0,1,1));
      vq.push_back(idle(1, 0,0,0,0,0,1,1));
      vq.push_back(mkv(1,1,9,0,1,1,0,1,1,0, 0,0,0,0,1, 0,0,0,0,0,1,1));
      vq.push_back(idle(1, 0,0,0,0,0,0,1));
      vq.push_back(mkv(0,1,1,1,10,1,0,2,1,0, 0,0,0,0,0, 0,0,0,0,0,0,1));
      vq.push_back(mkv(0,1,2,0,20,1,0,3,1,0, 0,0,0,0,0, 0,0,0,0,0,1,1));
      vq.push_back(mkv(0,1,3,1,30,1,0,4,1,0, 0,0,0,0,0, 0,0,0,0,0,2,1));
      vq.push_back(mkv(0,1,4,0,40,1,0,5,1,0, 0,0,0,0,0, 0,0,0,0,0,3,1));
      vq.push_back(mkv(0,1,7,1,70,1,0,7,1,0, 0,0,0,0,0, 0,0,0,0,0,4,0));
      vq.push_back(idle(1, 1,1,1,10,2,4,0));
      vq.push_back(idle(0, 0,0,0,0,0,3,1));
      vq.push_back(idle(1, 1,2,0,20,3,3,1));
      vq.push_back(idle(0, 0,0,0,0,0,2,1));
      vq.push_back(idle(1, 1,3,1,30,4,2,1));
      vq.push_back(idle(0, 0,0,0,0,0,1,1));
      vq.push_back(idle(1, 1,4,0,40,5,1,1));
      vq.push_back(idle(1, 0,0,0,0,0,0,1));
      vq.push_back(mkv(0,1,8,1,10,1,0,3,1,0, 0,0,0,0,0, 0,0,0,0,0,0,1));
      vq.push_back(mkv(0,1,10,0,0,0,12,6,1,0, 1,0,12,60,1, 1,8,1,10,3,1,1));
      vq.push_back(idle(1, 1,10,0,60,6,1,1));
      vq.push_back(idle(1, 0,0,0,0,0,0,1));
      vq.push_back(mkv(0,1,1,0,1,1,0,1,1,0, 0,0,0,0,0, 0,0,0,0,0,0,1));
      vq.push_back(mkv(0,1,2,0,2,1,0,1,1,0, 0,0,0,0,0, 0,0,0,0,0,1,1));
      vq.push_back(mkv(0,1,3,0,3,1,0,1,1,0, 0,0,0,0,0, 0,0,0,0,0,2,1));
      vq.push_back(mkv(1,1,4,0,4,1,0,1,1,0, 0,0,0,0,1, 0,0,0,0,0,3,1));
      vq.push_back(idle(1, 0,0,0,0,0,0,1));

      foreach (vq[i]) begin
         apply_in(vq[i]);
         #1;
         chk_outs($sformatf("row%0d", i), vq[i].e_iv, vq[i].e_rob, vq[i].e_op,
                  vq[i].e_dd, vq[i].e_dr, vq[i].e_occ, vq[i].e_rdy);
         @(posedge clk); #1;
      end

      // Asynchronous reset in the middle of a cycle with an issue pending.
      apply_in(mkv(0,1,1,0,8,1,0,2,1,0, 0,0,0,0,0, 0,0,0,0,0,0,0));
      @(posedge clk); #1;
      apply_in(idle(1, 0,0,0,0,0,0,0));
      #1;
      chk("async pre issue_valid", 32'(issue_valid), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async issue_valid",    32'(issue_valid),    0);
      chk("async dispatch_ready", 32'(dispatch_ready), 1);
      chk("async occupancy",      32'(occupancy),      0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("post reset occupancy", 32'(occupancy), 0);

      for (int c = 0; c < 3000; c++) begin
         int        idx;
         bit        hit, e_iv, a1, a2;
         logic [31:0] e_dd, e_dr;
         logic [3:0]  e_rob;
         logic        e_op;
         m_ent_t      ne;
         v = idle(0,0,0,0,0,0,0,0);
         v.fl  = ($urandom_range(0, 49) == 0);
         v.dv  = $urandom_range(0, 1);
         v.rob = $urandom_range(0, 15);
         v.op  = $urandom_range(0, 1);
         v.s1v = $urandom; v.s2v = $urandom;
         v.s1r = ($urandom_range(0, 2) != 0);
         v.s2r = ($urandom_range(0, 2) != 0);
         v.s1t = $urandom_range(0, 3); v.s2t = $urandom_range(0, 3);
         v.cv  = $urandom_range(0, 1);
         v.ls  = ($urandom_range(0, 3) == 0);
         v.ct  = $urandom_range(0, 3);
         v.cr  = $urandom;
         v.fu  = ($urandom_range(0, 2) != 0);
         apply_in(v);
         #1;

         hit = v.cv[0] && !v.ls[0];
         idx = -1;
         e_rob = '0; e_op = 1'b0; e_dd = '0; e_dr = '0;
         for (int i = 0; i < mq.size(); i++) begin
            a1 = mq[i].r1 || (BYP && hit && mq[i].t1 == v.ct[3:0]);
            a2 = mq[i].r2 || (BYP && hit && mq[i].t2 == v.ct[3:0]);
            if (idx < 0 && a1 && a2) begin
               idx   = i;
               e_rob = mq[i].rob;
               e_op  = mq[i].op;
               e_dd  = mq[i].r1 ? mq[i].v1 : v.cr;
               e_dr  = mq[i].r2 ? mq[i].v2 : v.cr;
            end
         end
         e_iv = v.fu[0] && !v.fl[0] && (idx >= 0);
         if (!e_iv) begin
            e_rob = '0; e_op = 1'b0; e_dd = '0; e_dr = '0;
         end
         chk_outs($sformatf("rand%0d", c), e_iv, e_rob, e_op, e_dd, e_dr,
                  mq.size(), (mq.size() < DEPTH));

         if (v.fl[0]) begin
            mq.delete();
         end else begin
            bit acc;
            acc = v.dv[0] && (mq.size() < DEPTH);
            if (e_iv) mq.delete(idx);
            foreach (mq[i]) begin
               if (hit && !mq[i].r1 && mq[i].t1 == v.ct[3:0]) begin mq[i].r1 = 1; mq[i].v1 = v.cr; end
               if (hit && !mq[i].r2 && mq[i].t2 == v.ct[3:0]) begin mq[i].r2 = 1; mq[i].v2 = v.cr; end
            end
            if (acc) begin
               ne.rob = v.rob[3:0]; ne.op = v.op[0];
               ne.v1 = v.s1v; ne.r1 = v.s1r[0]; ne.t1 = v.s1t[3:0];
               ne.v2 = v.s2v; ne.r2 = v.s2r[0]; ne.t2 = v.s2t[3:0];
               if (hit && !ne.r1 && ne.t1 == v.ct[3:0]) begin ne.r1 = 1; ne.v1 = v.cr; end
               if (hit && !ne.r2 && ne.t2 == v.ct[3:0]) begin ne.r2 = 1; ne.v2 = v.cr; end
               mq.push_back(ne);
            end
         end
         @(posedge clk); #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
